// File: rtl/core_scheduler.sv
// Per-core instruction scheduler: walks each instruction through
// FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE and keeps per-run cycle/instruction counters.
`timescale 1ns/1ps
module core_scheduler #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(THREADS):0]      thread_count,
  input  logic [2:0]                    fetcher_state,
  input  logic                          decoded_ret,
  input  logic [2*THREADS-1:0]          lsu_state,
  input  logic [PC_BITS*THREADS-1:0]    next_pc,
  output logic [2:0]                    core_state,
  output logic [PC_BITS-1:0]            current_pc,
  output logic                          done,
  output logic [15:0]                   cycle_count,
  output logic [15:0]                   instr_count
);

  localparam int TCW = $clog2(THREADS) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_e;

  state_e               state_q, state_d;
  logic [PC_BITS-1:0]   pc_q, pc_d;
  logic                 done_q, done_d;
  logic [15:0]          cyc_q, cyc_d;
  logic [15:0]          instr_q, instr_d;
  logic [TCW-1:0]       tc_q, tc_d;
  logic                 lsu_busy;

  // Only slot 0 of next_pc steers the shared PC; the other lanes are carried for the datapath.
  logic [PC_BITS*THREADS-1:0] unused_next_pc;
  assign unused_next_pc = next_pc;

  always_comb begin
    lsu_busy = 1'b0;
    for (int unsigned i = 0; i < THREADS; i++) begin
      if (i < 32'(tc_q) &&
          (lsu_state[2*i +: 2] == 2'b01 || lsu_state[2*i +: 2] == 2'b10))
        lsu_busy = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    cyc_d   = cyc_q;
    instr_d = instr_q;
    tc_d    = tc_q;

    if (state_q != S_IDLE && state_q != S_DONE && cyc_q != '1)
      cyc_d = cyc_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tc_d    = thread_count;
          pc_d    = '0;
          cyc_d   = '0;
          instr_d = '0;
          if (thread_count != '0) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_FETCH:   if (fetcher_state == 3'b010) state_d = S_DECODE;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT:    if (!lsu_busy) state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        if (instr_q != '1) instr_d = instr_q + 16'd1;
        if (decoded_ret) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          pc_d    = next_pc[PC_BITS-1:0];
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
      instr_q <= '0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
      instr_q <= instr_d;
      tc_q    <= tc_d;
    end
  end

  assign core_state  = state_q;
  assign current_pc  = pc_q;
  assign done        = done_q;
  assign cycle_count = cyc_q;
  assign instr_count = instr_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Scoreboard bench for core_scheduler: expected state-entry records are queued by the
// stimulus, and a monitor pops one on every core_state change.
`timescale 1ns/1ps
module tb_core_scheduler;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, REQUEST = 3'd3,
                         WAITS = 3'd4, EXECUTE = 3'd5, UPDATE = 3'd6, DONES = 3'd7;

  logic        clk = 1'b0;
  logic        reset, start, decoded_ret;
  logic [2:0]  thread_count;
  logic [2:0]  fetcher_state;
  logic [7:0]  lsu_state;
  logic [31:0] next_pc;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        done;
  logic [15:0] cycle_count, instr_count;

  core_scheduler #(.THREADS(4), .PC_BITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .fetcher_state(fetcher_state), .decoded_ret(decoded_ret), .lsu_state(lsu_state),
    .next_pc(next_pc), .core_state(core_state), .current_pc(current_pc), .done(done),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    int          dur;   // cycles expected in the previous state; 0 = don't care
    bit          full;
    logic [7:0]  pc;
    logic [15:0] cyc;
    logic [15:0] ins;
    logic        dn;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  int fetch_lat = 1, lsu_mode = 0, ret_idx = 0, nupd = 0;
  bit ret_noise = 1'b0;
  logic [7:0] pc_tab [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [2:0] st, input int dur, input bit full,
                          input logic [7:0] pc, input logic [15:0] cyc,
                          input logic [15:0] ins, input logic dn);
    exp_t e;
    e.st = st; e.dur = dur; e.full = full; e.pc = pc; e.cyc = cyc; e.ins = ins; e.dn = dn;
    q.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (core_state == s) hit = 1'b1;
    end
    if (!hit) chk($sformatf("timeout_waiting_state%0d", s), 32'(core_state), 32'(s));
  endtask

  task automatic pulse_start(input logic [2:0] tc);
    @(posedge clk); #1;
    thread_count = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Environment responder: fetcher latency, LSU patterns, next_pc and RET per UPDATE.
  initial begin
    int fcnt = 0, wcnt = 0;
    logic [1:0] s1;
    fetcher_state = 3'b000; lsu_state = '0; next_pc = '0; decoded_ret = 1'b0;
    forever begin
      @(negedge clk);
      fcnt = (core_state == FETCH) ? fcnt + 1 : 0;
      wcnt = (core_state == WAITS) ? wcnt + 1 : 0;
      fetcher_state = (core_state != FETCH) ? 3'b000 : (fcnt >= fetch_lat ? 3'b010 : 3'b001);
      s1 = (wcnt <= 3) ? 2'b10 : 2'b11;
      case (lsu_mode)
        1:       lsu_state = {2'b01, 2'b10, s1, 2'b00};
        2:       lsu_state = 8'b00_00_00_01;
        default: lsu_state = 8'b00_00_00_00;
      endcase
      if (core_state == UPDATE) begin
        next_pc     = {8'hA5, 8'hA5, 8'hA5, pc_tab[nupd]};
        decoded_ret = (nupd == ret_idx);
        nupd++;
      end else begin
        next_pc     = {8'hA5, 8'hA5, 8'hA5, 8'h5A};
        decoded_ret = ret_noise;
      end
    end
  end

  // Monitor: every state change must match the next queued record.
  initial begin
    logic [2:0] prev = IDLE;
    int cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (core_state !== prev) begin
        if (q.size() == 0) begin
          chk("unexpected_transition", 32'(core_state), 32'(prev));
        end else begin
          e = q.pop_front();
          chk($sformatf("state_after_%0d", prev), 32'(core_state), 32'(e.st));
          if (e.dur != 0) chk($sformatf("dur_in_%0d", prev), 32'(cnt), 32'(e.dur));
          if (e.full) begin
            chk($sformatf("pc_at_%0d", e.st), 32'(current_pc), 32'(e.pc));
            chk($sformatf("cyc_at_%0d", e.st), 32'(cycle_count), 32'(e.cyc));
            chk($sformatf("ins_at_%0d", e.st), 32'(instr_count), 32'(e.ins));
            chk($sformatf("done_at_%0d", e.st), 32'(done), 32'(e.dn));
          end
        end
        prev = core_state;
        cnt = 1;
      end else begin
        cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; thread_count = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_state", 32'(core_state), 0);
    chk("rst_pc", 32'(current_pc), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cyc", 32'(cycle_count), 0);
    chk("rst_ins", 32'(instr_count), 0);
    repeat (3) @(posedge clk);
    #1 chk("idle_without_start", 32'(core_state), 32'(IDLE));

    // Three instructions, fetch answers on the third FETCH cycle, RET on the third.
    fetch_lat = 3; lsu_mode = 0; ret_noise = 1'b0; nupd = 0; ret_idx = 2;
    pc_tab[0] = 8'd1; pc_tab[1] = 8'd2; pc_tab[2] = 8'd3;
    push_exp(FETCH, 0, 1, 8'd0, 16'd0, 16'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push_exp(DECODE, 3, 0, '0, '0, '0, 1'b0);
      push_exp(REQUEST, 1, 0, '0, '0, '0, 1'b0);
      push_exp(WAITS, 1, 0, '0, '0, '0, 1'b0);
      push_exp(EXECUTE, 1, 0, '0, '0, '0, 1'b0);
      push_exp(UPDATE, 1, 0, '0, '0, '0, 1'b0);
      if (k < 2) push_exp(FETCH, 1, 1, 8'(k + 1), 16'(8 * (k + 1)), 16'(k + 1), 1'b0);
    end
    push_exp(DONES, 1, 1, 8'd2, 16'd24, 16'd3, 1'b1);
    push_exp(IDLE, 1, 1, 8'd2, 16'd24, 16'd3, 1'b0);
    pulse_start(3'd4);
    wait_state(DONES, 100);
    wait_state(IDLE, 20);

    // Two active threads: slot 1 busy three WAIT cycles, inactive slots 2/3 busy forever.
    fetch_lat = 1; lsu_mode = 1; nupd = 0; ret_idx = 0;
    push_exp(FETCH, 0, 1, 8'd0, 16'd0, 16'd0, 1'b0);
    push_exp(DECODE, 1, 0, '0, '0, '0, 1'b0);
    push_exp(REQUEST, 1, 0, '0, '0, '0, 1'b0);
    push_exp(WAITS, 1, 0, '0, '0, '0, 1'b0);
    push_exp(EXECUTE, 4, 0, '0, '0, '0, 1'b0);
    push_exp(UPDATE, 1, 0, '0, '0, '0, 1'b0);
    push_exp(DONES, 1, 1, 8'd0, 16'd9, 16'd1, 1'b1);
    push_exp(IDLE, 1, 1, 8'd0, 16'd9, 16'd1, 1'b0);
    pulse_start(3'd2);
    wait_state(DONES, 100);
    wait_state(IDLE, 20);

    // Zero threads: straight to DONE with cleared counters.
    lsu_mode = 0;
    push_exp(DONES, 0, 1, 8'd0, 16'd0, 16'd0, 1'b1);
    push_exp(IDLE, 1, 1, 8'd0, 16'd0, 16'd0, 1'b0);
    pulse_start(3'd0);
    wait_state(IDLE, 20);

    // Asynchronous reset while stuck in WAIT.
    lsu_mode = 2;
    push_exp(FETCH, 0, 1, 8'd0, 16'd0, 16'd0, 1'b0);
    push_exp(DECODE, 1, 0, '0, '0, '0, 1'b0);
    push_exp(REQUEST, 1, 0, '0, '0, '0, 1'b0);
    push_exp(WAITS, 1, 0, '0, '0, '0, 1'b0);
    push_exp(IDLE, 0, 1, 8'd0, 16'd0, 16'd0, 1'b0);
    pulse_start(3'd4);
    wait_state(WAITS, 50);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b0;
    #2;
    chk("async_rst_state", 32'(core_state), 0);
    chk("async_rst_pc", 32'(current_pc), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_cyc", 32'(cycle_count), 0);
    chk("async_rst_ins", 32'(instr_count), 0);
    lsu_mode = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("idle_after_async_rst", 32'(core_state), 32'(IDLE));

    // PC wrap via next_pc, start toggled during the run, RET noise outside UPDATE.
    fetch_lat = 1; nupd = 0; ret_idx = 2; ret_noise = 1'b1;
    pc_tab[0] = 8'hFF; pc_tab[1] = 8'h00; pc_tab[2] = 8'h33;
    push_exp(FETCH, 0, 1, 8'd0, 16'd0, 16'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push_exp(DECODE, 1, 0, '0, '0, '0, 1'b0);
      push_exp(REQUEST, 1, 0, '0, '0, '0, 1'b0);
      push_exp(WAITS, 1, 0, '0, '0, '0, 1'b0);
      push_exp(EXECUTE, 1, 0, '0, '0, '0, 1'b0);
      push_exp(UPDATE, 1, 0, '0, '0, '0, 1'b0);
      if (k < 2) push_exp(FETCH, 1, 1, pc_tab[k], 16'(6 * (k + 1)), 16'(k + 1), 1'b0);
    end
    push_exp(DONES, 1, 1, 8'h00, 16'd18, 16'd3, 1'b1);
    push_exp(IDLE, 1, 1, 8'h00, 16'd18, 16'd3, 1'b0);
    @(posedge clk); #1;
    thread_count = 3'd1; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 start = ~start;
    end
    start = 1'b0;
    wait_state(DONES, 100);
    wait_state(IDLE, 20);
    ret_noise = 1'b0;

    // start held high in DONE for five cycles.
    push_exp(DONES, 0, 1, 8'd0, 16'd0, 16'd0, 1'b1);
    push_exp(IDLE, 6, 1, 8'd0, 16'd0, 16'd0, 1'b0);
    @(posedge clk); #1;
    thread_count = 3'd0; start = 1'b1;
    repeat (6) @(posedge clk);
    #1 start = 1'b0;
    wait_state(IDLE, 20);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_scheduler.md
CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 SHALL have parameter THREADS, default 4, meaning the number of thread lanes per core (power of 2, 1..16).
REQ-002 SHALL have parameter PC_BITS, default 8, meaning the program counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; assertion (0) forces the reset state immediately, and release is sampled on clk.
REQ-005 SHALL have port start  input  1  request to run a block from PC 0.
REQ-006 SHALL have port thread_count  input  $clog2(THREADS)+1  number of active threads, latched when start is accepted.
REQ-007 SHALL have port fetcher_state  input  3  fetcher status: 000 IDLE, 001 FETCHING, 010 FETCHED.
REQ-008 SHALL have port decoded_ret  input  1  decoded instruction is RET.
REQ-009 SHALL have port lsu_state  input  2*THREADS  per-thread LSU state (slot i = bits 2i+1:2i): 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE.
REQ-010 SHALL have port next_pc  input  PC_BITS*THREADS  per-thread next PC (slot i = bits PC_BITS*(i+1)-1 : PC_BITS*i).
REQ-011 SHALL have port core_state  output  3  state: 000 IDLE, 001 FETCH, 010 DECODE, 011 REQUEST, 100 WAIT, 101 EXECUTE, 110 UPDATE, 111 DONE.
REQ-012 SHALL have port current_pc  output  PC_BITS  PC of the instruction in flight.
REQ-013 SHALL have port done  output  1  block finished.
REQ-014 SHALL have port cycle_count  output  16  clocks spent outside IDLE and DONE for the current run; saturates at 16'hFFFF.
REQ-015 SHALL have port instr_count  output  16  instructions retired (UPDATE visits) for the current run; saturates at 16'hFFFF.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 IDLE: when start=1 and the latched thread_count is nonzero, the block SHALL go to FETCH and clear current_pc, cycle_count and instr_count to 0; when start=1 and thread_count=0, it SHALL go directly to DONE with both counters at 0.
REQ-018 FETCH: the block SHALL remain in FETCH until fetcher_state=010, then go to DECODE on the next edge.
REQ-019 DECODE->REQUEST and REQUEST->WAIT SHALL each take exactly 1 cycle, unconditionally.
REQ-020 WAIT: the block SHALL remain in WAIT while any active thread (index < latched thread_count) has lsu_state 01 or 10, and SHALL go to EXECUTE otherwise; inactive threads SHALL be ignored.
REQ-021 EXECUTE->UPDATE SHALL take exactly 1 cycle.
REQ-022 UPDATE: instr_count SHALL increment by 1; if decoded_ret=1 the block SHALL go to DONE with current_pc unchanged, otherwise current_pc SHALL load next_pc slot 0 and the block SHALL go to FETCH.
REQ-023 The minimum instruction period with the fetcher returning 010 on the first FETCH cycle SHALL be 6 cycles (FETCH through UPDATE).
REQ-024 DONE: done SHALL be 1 and core_state SHALL be 111; the counters and current_pc SHALL hold; when start=0 the block SHALL go to IDLE and clear done on the same edge.
REQ-025 start SHALL be ignored in every state except IDLE and the DONE exit condition.
REQ-026 cycle_count SHALL increment on every edge where core_state is FETCH..UPDATE.
REQ-027 current_pc SHALL wrap modulo 2^PC_BITS as supplied by next_pc; the block SHALL perform no PC arithmetic of its own.
REQ-028 decoded_ret SHALL be sampled only in UPDATE.

Reset
REQ-029 When reset=0, the block SHALL force core_state=000, current_pc=0, done=0, cycle_count=0, instr_count=0 and latched thread_count=0, asynchronously and in any state, including mid-WAIT.
REQ-030 The first transition after reset release SHALL require start=1 sampled on a rising edge.

Verification
REQ-031 Reset, then start=1, thread_count=4, fetcher returns 010 after 2 FETCH cycles, all LSU 00, next_pc0=1, ret on the 3rd instruction -> state trace per REQ-018..022; done=1; current_pc=2; instr_count=3; cycle_count=24.
REQ-032 In WAIT with thread_count=2: lsu slot 3=01 (inactive), slot 1=10 for 3 cycles then 11 -> WAIT lasts 4 cycles; slot 3 has no effect.
REQ-033 start=1 with thread_count=0 -> core_state=111 and done=1 one edge later; counters=0.
REQ-034 Assert reset=0 asynchronously mid-WAIT -> outputs reach their reset values before the next clk edge; no transition occurs until start is next sampled high.
REQ-035 next_pc0=8'hFF then 8'h00 across two UPDATE visits -> current_pc=FF, then 00; toggling start in FETCH has no effect.
REQ-036 In DONE, hold start=1 for 5 cycles then drop it -> done stays 1 for those 5 cycles, then IDLE and done=0 on the following edge.
